// File: rtl/bit_seq_pkg.sv
// bit_seq_pkg: shared constants for the bit_seq pattern sequencer.
//   - Avalon register addresses ADDR_CTRL..ADDR_IRQ
//   - CTRL (write/read) and IRQ bit positions
//   - FSM state encoding
package bit_seq_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_MANUAL  = 4'd1;
  localparam logic [3:0] ADDR_PATTERN = 4'd2;
  localparam logic [3:0] ADDR_LEN     = 4'd3;
  localparam logic [3:0] ADDR_DIV_LO  = 4'd4;
  localparam logic [3:0] ADDR_DIV_HI  = 4'd5;
  localparam logic [3:0] ADDR_REPEAT  = 4'd6;
  localparam logic [3:0] ADDR_IRQ     = 4'd7;

  // CTRL write bits
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ABORT = 1;
  // CTRL read bits
  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;
  // IRQ register bits
  localparam int unsigned IRQ_EN_BIT   = 0;
  localparam int unsigned IRQ_PEND_BIT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bit_seq_prescaler.sv
// bit_seq_prescaler: counts 0..div while enabled and flags the last count.
//   csi_clk, csi_reset : clock, synchronous active-high reset
//   clr                : synchronous clear of the count
//   en                 : count enable
//   div                : terminal count (clocks per step = div+1)
//   tick_c             : combinational step tick, high while en and count==div
module bit_seq_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             csi_clk,
  input  logic             csi_reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] presc;

  assign tick_c = en && (presc == div);

  always_ff @(posedge csi_clk) begin
    if (csi_reset || clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick_c ? '0 : presc + DIV_W'(1);
    end
  end

endmodule

// File: rtl/bit_seq.sv
// bit_seq: Avalon-MM slave driving one output bit from a programmable
// serial pattern; follows a manual level when idle.
//   csi_clk, csi_reset   : clock, synchronous active-high reset
//   avs_s1_*             : 4-bit address, 8-bit data slave, 1-cycle read latency
//   coe_bit              : sequenced output bit (registered)
//   ins_irq              : completion interrupt (only with BIT_SEQ_IRQ_EN)
// Optional feature macro: BIT_SEQ_IRQ_EN (register 7 and ins_irq).
module bit_seq
  import bit_seq_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned REP_W = 8
) (
  input  logic       csi_clk,
  input  logic       csi_reset,
  input  logic [3:0] avs_s1_address,
  input  logic       avs_s1_read,
  output logic [7:0] avs_s1_readdata,
  input  logic       avs_s1_write,
  input  logic [7:0] avs_s1_writedata,
  output logic       coe_bit
`ifdef BIT_SEQ_IRQ_EN
  ,
  output logic       ins_irq
`endif
);

  state_t           state;
  logic             manual;
  logic [7:0]       pattern;
  logic [2:0]       len_r;
  logic [7:0]       div_lo;
  logic [7:0]       div_hi;
  logic [REP_W-1:0] repeat_r;
  logic             done;

  // Shadow copies taken at START so register writes cannot disturb a run
  logic [7:0]       sh_pattern;
  logic [2:0]       sh_len;
  logic [DIV_W-1:0] sh_div;
  logic [REP_W-1:0] sh_repeat;
  logic [2:0]       idx;
  logic [REP_W-1:0] rep;

`ifdef BIT_SEQ_IRQ_EN
  logic irq_en;
  logic pend;
`endif

  logic       wr_ctrl_c;
  logic       start_c;
  logic       abort_c;
  logic       step_c;
  logic       last_bit_c;
  logic       finish_c;
  logic [2:0] next_idx_c;
  logic [7:0] rdata_c;

  assign wr_ctrl_c  = avs_s1_write && (avs_s1_address == ADDR_CTRL);
  // ABORT wins over START in the same write
  assign start_c    = wr_ctrl_c && avs_s1_writedata[CTRL_START] &&
                      !avs_s1_writedata[CTRL_ABORT] && (state == ST_IDLE);
  assign abort_c    = wr_ctrl_c && avs_s1_writedata[CTRL_ABORT] && (state == ST_RUN);
  assign last_bit_c = (idx == sh_len);
  assign next_idx_c = last_bit_c ? 3'd0 : idx + 3'd1;
  // REPEAT==0 never finishes; rep simply wraps
  assign finish_c   = step_c && last_bit_c && (sh_repeat != '0) &&
                      ((rep + REP_W'(1)) == sh_repeat);

  bit_seq_prescaler #(.DIV_W(DIV_W)) u_presc (
    .csi_clk   (csi_clk),
    .csi_reset (csi_reset),
    .clr       (start_c),
    .en        (state == ST_RUN),
    .div       (sh_div),
    .tick_c    (step_c)
  );

  // Read-data mux
  always_comb begin
    rdata_c = '0;
    case (avs_s1_address)
      ADDR_CTRL: begin
        rdata_c[STAT_BUSY] = (state == ST_RUN);
        rdata_c[STAT_DONE] = done;
      end
      ADDR_MANUAL:  rdata_c[0] = manual;
      ADDR_PATTERN: rdata_c    = pattern;
      ADDR_LEN:     rdata_c    = 8'(len_r);
      ADDR_DIV_LO:  rdata_c    = div_lo;
      ADDR_DIV_HI:  rdata_c    = div_hi;
      ADDR_REPEAT:  rdata_c    = 8'(repeat_r);
`ifdef BIT_SEQ_IRQ_EN
      ADDR_IRQ: begin
        rdata_c[IRQ_EN_BIT]   = irq_en;
        rdata_c[IRQ_PEND_BIT] = pend;
      end
`endif
      default: ;
    endcase
  end

  // Register file, FSM and output bit
  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state           <= ST_IDLE;
      manual          <= 1'b0;
      pattern         <= '0;
      len_r           <= '0;
      div_lo          <= '0;
      div_hi          <= '0;
      repeat_r        <= '0;
      done            <= 1'b0;
      sh_pattern      <= '0;
      sh_len          <= '0;
      sh_div          <= '0;
      sh_repeat       <= '0;
      idx             <= '0;
      rep             <= '0;
      coe_bit         <= 1'b0;
      avs_s1_readdata <= '0;
`ifdef BIT_SEQ_IRQ_EN
      irq_en          <= 1'b0;
      pend            <= 1'b0;
      ins_irq         <= 1'b0;
`endif
    end else begin
      if (avs_s1_write) begin
        case (avs_s1_address)
          ADDR_MANUAL:  manual   <= avs_s1_writedata[0];
          ADDR_PATTERN: pattern  <= avs_s1_writedata;
          ADDR_LEN:     len_r    <= avs_s1_writedata[2:0];
          ADDR_DIV_LO:  div_lo   <= avs_s1_writedata;
          ADDR_DIV_HI:  div_hi   <= avs_s1_writedata;
          ADDR_REPEAT:  repeat_r <= REP_W'(avs_s1_writedata);
`ifdef BIT_SEQ_IRQ_EN
          ADDR_IRQ:     irq_en   <= avs_s1_writedata[IRQ_EN_BIT];
`endif
          default: ;
        endcase
      end

      if (avs_s1_read) begin
        avs_s1_readdata <= rdata_c;
      end

      case (state)
        ST_IDLE: begin
          coe_bit <= manual;
          if (start_c) begin
            state      <= ST_RUN;
            sh_pattern <= pattern;
            sh_len     <= len_r;
            sh_div     <= DIV_W'({div_hi, div_lo});
            sh_repeat  <= repeat_r;
            idx        <= '0;
            rep        <= '0;
            done       <= 1'b0;
            coe_bit    <= pattern[0];
          end
        end
        ST_RUN: begin
          if (abort_c) begin
            state   <= ST_IDLE;
            coe_bit <= manual;
          end else if (finish_c) begin
            state   <= ST_IDLE;
            done    <= 1'b1;
            coe_bit <= manual;
          end else if (step_c) begin
            // Present the next bit on the step edge so each bit lasts DIV+1 clocks
            idx     <= next_idx_c;
            coe_bit <= sh_pattern[next_idx_c];
            if (last_bit_c) begin
              rep <= rep + REP_W'(1);
            end
          end else begin
            coe_bit <= sh_pattern[idx];
          end
        end
        default: state <= ST_IDLE;
      endcase

`ifdef BIT_SEQ_IRQ_EN
      // Set wins over a simultaneous write-1-clear
      if (finish_c) begin
        pend <= 1'b1;
      end else if (avs_s1_write && (avs_s1_address == ADDR_IRQ) &&
                   avs_s1_writedata[IRQ_PEND_BIT]) begin
        pend <= 1'b0;
      end
      ins_irq <= pend && irq_en;
`endif
    end
  end

endmodule

// File: tb/tb_bit_seq.sv
module tb_bit_seq;

  logic       csi_clk;
  logic       csi_reset;
  logic [3:0] avs_s1_address;
  logic       avs_s1_read;
  logic [7:0] avs_s1_readdata;
  logic       avs_s1_write;
  logic [7:0] avs_s1_writedata;
  logic       coe_bit;
`ifdef BIT_SEQ_IRQ_EN
  logic       ins_irq;
`endif

  int vectors;
  int miscompares;

  bit_seq #(.DIV_W(16), .REP_W(8)) dut (
    .csi_clk          (csi_clk),
    .csi_reset        (csi_reset),
    .avs_s1_address   (avs_s1_address),
    .avs_s1_read      (avs_s1_read),
    .avs_s1_readdata  (avs_s1_readdata),
    .avs_s1_write     (avs_s1_write),
    .avs_s1_writedata (avs_s1_writedata),
    .coe_bit          (coe_bit)
`ifdef BIT_SEQ_IRQ_EN
    ,
    .ins_irq          (ins_irq)
`endif
  );

  initial csi_clk = 1'b0;
  always #5 csi_clk = ~csi_clk;

  // Bus helpers: return at the falling edge after the capturing rising edge
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge csi_clk);
    avs_s1_address   = a;
    avs_s1_writedata = d;
    avs_s1_write     = 1'b1;
    @(negedge csi_clk);
    avs_s1_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge csi_clk);
    avs_s1_address = a;
    avs_s1_read    = 1'b1;
    @(negedge csi_clk);
    avs_s1_read    = 1'b0;
    d = avs_s1_readdata;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    csi_reset = 1'b1;
    repeat (3) @(negedge csi_clk);
    csi_reset = 1'b0;
    vectors++;
    if (coe_bit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_coe: got %b expected 0", coe_bit);
    end
    for (int a = 0; a < 16; a++) begin
      bus_read(4'(a), rd);
      vectors++;
      if (rd !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_read addr %0d: got %h expected 00", a, rd);
      end
    end
  endtask

  task automatic test_manual();
    logic [7:0] rd;
    bus_write(4'd1, 8'h01);
    vectors++;
    if (coe_bit !== 1'b0) begin
      miscompares++;
      $display("FAIL manual_write_edge: got %b expected 0", coe_bit);
    end
    @(negedge csi_clk);
    vectors++;
    if (coe_bit !== 1'b1) begin
      miscompares++;
      $display("FAIL manual_follow: got %b expected 1", coe_bit);
    end
    bus_read(4'd0, rd);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++;
      $display("FAIL manual_busy: got %h expected 00", rd);
    end
    bus_write(4'd5, 8'h5A);
    bus_read(4'd5, rd);
    vectors++;
    if (rd !== 8'h5A) begin
      miscompares++;
      $display("FAIL div_hi_readback: got %h expected 5a", rd);
    end
    bus_write(4'd3, 8'hFF);
    bus_read(4'd3, rd);
    vectors++;
    if (rd !== 8'h07) begin
      miscompares++;
      $display("FAIL len_readback: got %h expected 07", rd);
    end
    bus_write(4'd9, 8'hFF);
    bus_read(4'd9, rd);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++;
      $display("FAIL unused_addr: got %h expected 00", rd);
    end
  endtask

  task automatic test_pattern();
    logic exp_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_bit;
    bus_write(4'd2, 8'hA5);
    bus_write(4'd3, 8'h07);
    bus_write(4'd4, 8'h02);
    bus_write(4'd5, 8'h00);
    bus_write(4'd6, 8'h01);
    bus_write(4'd0, 8'h01);
    for (int k = 0; k <= 24; k++) begin
      exp_bit = (k < 24) ? exp_seq[k / 3] : 1'b1;
      vectors++;
      if (coe_bit !== exp_bit) begin
        miscompares++;
        $display("FAIL pattern_bit k=%0d: got %b expected %b", k, coe_bit, exp_bit);
      end
      if (k >= 1) begin
        vectors++;
        if (avs_s1_readdata !== 8'h01) begin
          miscompares++;
          $display("FAIL pattern_busy k=%0d: got %h expected 01", k, avs_s1_readdata);
        end
      end else begin
        avs_s1_address = 4'd0;
        avs_s1_read    = 1'b1;
      end
      @(negedge csi_clk);
    end
    avs_s1_read = 1'b0;
    vectors++;
    if (avs_s1_readdata !== 8'h02) begin
      miscompares++;
      $display("FAIL pattern_done: got %h expected 02", avs_s1_readdata);
    end
  endtask

  task automatic test_repeat_shadow();
    logic exp_seq [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] rd;
    bus_write(4'd2, 8'h01);
    bus_write(4'd3, 8'h01);
    bus_write(4'd4, 8'h00);
    bus_write(4'd6, 8'h03);
    bus_write(4'd0, 8'h01);
    for (int k = 0; k <= 6; k++) begin
      vectors++;
      if (coe_bit !== exp_seq[k]) begin
        miscompares++;
        $display("FAIL repeat_bit k=%0d: got %b expected %b", k, coe_bit, exp_seq[k]);
      end
      if (k == 1) begin
        avs_s1_address   = 4'd2;
        avs_s1_writedata = 8'hFF;
        avs_s1_write     = 1'b1;
      end else begin
        avs_s1_write = 1'b0;
      end
      @(negedge csi_clk);
    end
    bus_read(4'd0, rd);
    vectors++;
    if (rd !== 8'h02) begin
      miscompares++;
      $display("FAIL repeat_done: got %h expected 02", rd);
    end
    bus_read(4'd2, rd);
    vectors++;
    if (rd !== 8'hFF) begin
      miscompares++;
      $display("FAIL repeat_pattern_reg: got %h expected ff", rd);
    end
  endtask

  task automatic test_len0_boundary();
    bus_write(4'd2, 8'h00);
    bus_write(4'd3, 8'h00);
    bus_write(4'd4, 8'h01);
    bus_write(4'd6, 8'h02);
    bus_write(4'd0, 8'h01);
    for (int k = 0; k <= 4; k++) begin
      vectors++;
      if (coe_bit !== ((k == 4) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL len0_bit k=%0d: got %b expected %b", k, coe_bit, (k == 4));
      end
      @(negedge csi_clk);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    bus_write(4'd2, 8'h00);
    bus_write(4'd3, 8'h07);
    bus_write(4'd4, 8'h00);
    bus_write(4'd6, 8'h00);
    bus_write(4'd0, 8'h01);
    repeat (50) @(negedge csi_clk);
    bus_read(4'd0, rd);
    vectors++;
    if (rd !== 8'h01) begin
      miscompares++;
      $display("FAIL infinite_busy: got %h expected 01", rd);
    end
    vectors++;
    if (coe_bit !== 1'b0) begin
      miscompares++;
      $display("FAIL infinite_bit: got %b expected 0", coe_bit);
    end
    bus_write(4'd0, 8'h02);
    vectors++;
    if (coe_bit !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_coe: got %b expected 1", coe_bit);
    end
    bus_read(4'd0, rd);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_status: got %h expected 00", rd);
    end
    bus_write(4'd0, 8'h03);
    bus_read(4'd0, rd);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++;
      $display("FAIL start_abort_status: got %h expected 00", rd);
    end
    vectors++;
    if (coe_bit !== 1'b1) begin
      miscompares++;
      $display("FAIL start_abort_coe: got %b expected 1", coe_bit);
    end
  endtask

  task automatic test_irq();
`ifdef BIT_SEQ_IRQ_EN
    bus_write(4'd7, 8'h01);
    bus_write(4'd2, 8'h00);
    bus_write(4'd3, 8'h00);
    bus_write(4'd4, 8'h00);
    bus_write(4'd6, 8'h01);
    bus_write(4'd0, 8'h01);
    @(negedge csi_clk);
    vectors++;
    if (ins_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_at_done: got %b expected 0", ins_irq);
    end
    @(negedge csi_clk);
    vectors++;
    if (ins_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise: got %b expected 1", ins_irq);
    end
    bus_write(4'd7, 8'h03);
    @(negedge csi_clk);
    vectors++;
    if (ins_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear: got %b expected 0", ins_irq);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] rd;
    bus_write(4'd2, 8'hFF);
    bus_write(4'd6, 8'h00);
    bus_write(4'd0, 8'h01);
    repeat (5) @(negedge csi_clk);
    csi_reset = 1'b1;
    @(negedge csi_clk);
    csi_reset = 1'b0;
    vectors++;
    if (coe_bit !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset_coe: got %b expected 0", coe_bit);
    end
    bus_read(4'd0, rd);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++;
      $display("FAIL midrun_reset_status: got %h expected 00", rd);
    end
    bus_read(4'd2, rd);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++;
      $display("FAIL midrun_reset_pattern: got %h expected 00", rd);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    csi_reset        = 1'b1;
    avs_s1_address   = 4'd0;
    avs_s1_read      = 1'b0;
    avs_s1_write     = 1'b0;
    avs_s1_writedata = 8'h00;
    test_reset();
    test_manual();
    test_pattern();
    test_repeat_shadow();
    test_len0_boundary();
    test_abort();
    test_irq();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
